// File: rtl/sprite_line_if.sv
// Bus bundle for sprite_line_engine.
// Carries descriptor writes, the scanline request and the pixel stage.
interface sprite_line_if #(
  parameter int NUM_SPRITES  = 8,
  parameter int size_x       = 10,
  parameter int size_y       = 9,
  parameter int size_address = 17
);
  localparam int IW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

  logic                    wr_en;
  logic [IW-1:0]           wr_sel;
  logic [31:0]             wr_data;
  logic                    wr_ready;
  logic                    line_start;
  logic [size_y-1:0]       line_y;
  logic                    line_ready;
  logic                    pixel_tick;
  logic                    active_area;
  logic [size_x-1:0]       pixel_x;
  logic                    sprite_on;
  logic [IW-1:0]           sprite_id;
  logic [size_address-1:0] memory_address;
  logic                    count_finished;

  modport master (
    output wr_en, wr_sel, wr_data,
    output line_start, line_y,
    output pixel_tick, active_area, pixel_x,
    input  wr_ready, line_ready,
    input  sprite_on, sprite_id, memory_address, count_finished
  );

  modport slave (
    input  wr_en, wr_sel, wr_data,
    input  line_start, line_y,
    input  pixel_tick, active_area, pixel_x,
    output wr_ready, line_ready,
    output sprite_on, sprite_id, memory_address, count_finished
  );
endinterface

// File: rtl/sprite_line_engine.sv
// Multi-sprite line engine: per-line descriptor scan in blanking,
// priority sprite lookup and memory addressing per pixel tick.
module sprite_line_engine #(
  parameter int NUM_SPRITES  = 8,
  parameter int size_x       = 10,
  parameter int size_y       = 9,
  parameter int size_address = 17,
  parameter int SPRITE_W     = 20,
  parameter int SPRITE_H     = 20
) (
  input  logic           clk,
  input  logic           reset,
  sprite_line_if.slave   bus
);
  localparam int IW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam int YC = ((size_y > 9) ? size_y : 9) + 1;
  localparam int XC = ((size_x > 10) ? size_x : 10) + 1;
  localparam int AW = size_address;
  localparam logic [IW-1:0] LAST = IW'(NUM_SPRITES - 1);

  typedef struct packed {
    logic       en;
    logic [8:0] slot;
    logic [2:0] rsv;
    logic [8:0] y;
    logic [9:0] x;
  } desc_t;

  typedef enum logic [1:0] {IDLE, SCAN, READY} state_t;

  state_t                 state, state_nx;
  desc_t                  tab_q  [NUM_SPRITES];
  desc_t                  line_q [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] mask_q;
  logic [size_y-1:0]      ly_q;
  logic [IW-1:0]          idx_q;

  desc_t                  scan_d;
  logic                   scan_hit;
  logic [NUM_SPRITES-1:0] hit;
  logic                   hit_any;
  logic [IW-1:0]          win;
  desc_t                  win_d;
  logic [XC-1:0]          px_e;
  logic [XC-1:0]          dx;
  logic [YC-1:0]          dy;
  logic [AW-1:0]          addr_nx;

  assign bus.wr_ready   = (state != SCAN);
  assign bus.line_ready = (state == READY);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.line_start) state_nx = SCAN;
      SCAN:    if (!bus.line_start && idx_q == LAST)
                 state_nx = READY;
      READY:   if (bus.line_start) state_nx = SCAN;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPRITES; i++)
        tab_q[i] <= '0;
    end else if (bus.wr_en && bus.wr_ready &&
                 int'(bus.wr_sel) < NUM_SPRITES) begin
      tab_q[bus.wr_sel] <= desc_t'(bus.wr_data);
    end
  end

  // Extra headroom bit keeps y + SPRITE_H from wrapping near the bottom.
  assign scan_d = tab_q[idx_q];

  always_comb begin
    scan_hit = scan_d.en &&
               (YC'(ly_q) >= YC'(scan_d.y)) &&
               (YC'(ly_q) <  YC'(scan_d.y) + YC'(SPRITE_H));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q <= '0;
      ly_q   <= '0;
      idx_q  <= '0;
    end else if (bus.line_start) begin
      mask_q <= '0;
      ly_q   <= bus.line_y;
      idx_q  <= '0;
    end else if (state == SCAN) begin
      mask_q[idx_q] <= scan_hit;
      idx_q         <= idx_q + IW'(1);
    end
  end

  // Per-line snapshot so table writes in READY wait for the next line.
  always_ff @(posedge clk) begin
    if (!reset && !bus.line_start && state == SCAN)
      line_q[idx_q] <= scan_d;
  end

  always_comb begin
    hit  = '0;
    px_e = XC'(bus.pixel_x);
    for (int i = 0; i < NUM_SPRITES; i++)
      hit[i] = mask_q[i] &&
               (px_e >= XC'(line_q[i].x)) &&
               (px_e <  XC'(line_q[i].x) + XC'(SPRITE_W));
  end

  always_comb begin
    hit_any = 1'b0;
    win     = '0;
    win_d   = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_any = 1'b1;
        win     = IW'(i);
        win_d   = line_q[i];
      end
    end
    dx      = px_e - XC'(win_d.x);
    dy      = YC'(ly_q) - YC'(win_d.y);
    addr_nx = AW'(win_d.slot) * AW'(SPRITE_W * SPRITE_H)
            + AW'(dy) * AW'(SPRITE_W)
            + AW'(dx);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.sprite_on      <= 1'b0;
      bus.sprite_id      <= '0;
      bus.memory_address <= '0;
      bus.count_finished <= 1'b0;
    end else if (bus.pixel_tick) begin
      if (bus.active_area && bus.line_ready && hit_any) begin
        bus.sprite_on      <= 1'b1;
        bus.sprite_id      <= win;
        bus.memory_address <= addr_nx;
        bus.count_finished <= (dx == XC'(SPRITE_W - 1));
      end else begin
        bus.sprite_on      <= 1'b0;
        bus.count_finished <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sprite_line_engine.sv
// Self-checking bench for sprite_line_engine.
// Directed vectors plus a per-cycle reference model.
module tb_sprite_line_engine;
  localparam int N = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sprite_line_if bus ();

  sprite_line_engine dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic en, input logic [8:0] slot,
                                     input logic [8:0] y, input logic [9:0] x);
    return {en, slot, 3'b000, y, x};
  endfunction

  // Reference model
  logic [31:0] m_tab  [N];
  logic [31:0] m_line [N];
  int m_ly = 0;
  int m_left = 0;
  bit m_valid = 0;
  bit armed = 0;
  bit e_on = 0;
  bit e_cf = 0;
  int e_id = 0;
  int e_addr = 0;

  function automatic void m_pixel(input int px, output bit on, output int id,
                                  output int addr, output bit cf);
    on = 0; id = 0; addr = 0; cf = 0;
    for (int i = 0; i < N; i++) begin
      int y;
      int x;
      int s;
      y = int'(m_line[i][18:10]);
      x = int'(m_line[i][9:0]);
      s = int'(m_line[i][30:22]);
      if (!on && m_line[i][31] && m_ly >= y && m_ly < y + 20 &&
          px >= x && px < x + 20) begin
        on = 1;
        id = i;
        addr = (s * 400 + (m_ly - y) * 20 + (px - x)) % 131072;
        cf = (px - x == 19);
      end
    end
  endfunction

  always @(posedge clk) begin
    bit rdy;
    bit wok;
    bit on;
    bit cf;
    int id;
    int addr;
    rdy = m_valid && m_left == 0;
    wok = (m_left == 0);
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_tab[i] = '0;
        m_line[i] = '0;
      end
      m_ly = 0; m_left = 0; m_valid = 0; armed = 1;
      e_on = 0; e_cf = 0; e_id = 0; e_addr = 0;
    end else begin
      if (bus.pixel_tick) begin
        m_pixel(int'(bus.pixel_x), on, id, addr, cf);
        if (bus.active_area && rdy && on) begin
          e_on = 1; e_id = id; e_addr = addr; e_cf = cf;
        end else begin
          e_on = 0; e_cf = 0;
        end
      end
      if (bus.wr_en && wok) m_tab[bus.wr_sel] = bus.wr_data;
      if (bus.line_start) begin
        m_left = N; m_valid = 1; m_ly = int'(bus.line_y);
        for (int i = 0; i < N; i++) m_line[i] = m_tab[i];
      end else if (m_left > 0) begin
        m_left--;
      end
    end
    #1;
    if (armed) begin
      chk("m_sprite_on", bus.sprite_on, e_on);
      chk("m_sprite_id", bus.sprite_id, e_id);
      chk("m_address", bus.memory_address, e_addr);
      chk("m_count_finished", bus.count_finished, e_cf);
      chk("m_line_ready", bus.line_ready, m_valid && m_left == 0);
      chk("m_wr_ready", bus.wr_ready, m_left == 0);
    end
  end

  task automatic wr(input int sel, input logic [31:0] d);
    bus.wr_en = 1; bus.wr_sel = sel[2:0]; bus.wr_data = d;
    @(negedge clk);
    bus.wr_en = 0;
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!bus.line_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("ready_timeout", bus.line_ready, 1);
  endtask

  task automatic start_line(input int y, input bit timed);
    bus.line_y = y[8:0]; bus.line_start = 1;
    @(negedge clk);
    bus.line_start = 0;
    if (timed) begin
      repeat (7) @(negedge clk);
      chk("ready_before_9", bus.line_ready, 0);
      @(negedge clk);
      chk("ready_at_9", bus.line_ready, 1);
    end else begin
      wait_ready();
    end
  endtask

  task automatic pix(input int x, input bit act);
    repeat (3) @(negedge clk);
    bus.pixel_tick = 1; bus.pixel_x = x[9:0]; bus.active_area = act;
    @(negedge clk);
    bus.pixel_tick = 0;
  endtask

  initial begin
    int k;
    int nc;
    bus.wr_en = 0; bus.wr_sel = '0; bus.wr_data = '0;
    bus.line_start = 0; bus.line_y = '0;
    bus.pixel_tick = 0; bus.active_area = 0; bus.pixel_x = '0;
    reset = 1;
    repeat (2) @(negedge clk);
    chk("rst_on", bus.sprite_on, 0);
    chk("rst_addr", bus.memory_address, 0);
    chk("rst_line_ready", bus.line_ready, 0);
    chk("rst_wr_ready", bus.wr_ready, 1);
    reset = 0;

    wr(0, mk(1, 2, 50, 100));
    start_line(55, 1);
    pix(103, 1);
    chk("p103_on", bus.sprite_on, 1);
    chk("p103_id", bus.sprite_id, 0);
    chk("p103_addr", bus.memory_address, 903);
    pix(103, 0);
    chk("inactive_on", bus.sprite_on, 0);
    chk("inactive_hold", bus.memory_address, 903);

    wr(1, mk(1, 3, 50, 105));
    start_line(55, 0);
    pix(110, 1);
    chk("p110_id", bus.sprite_id, 0);
    chk("p110_addr", bus.memory_address, 910);
    pix(120, 1);
    chk("p120_id", bus.sprite_id, 1);
    chk("p120_addr", bus.memory_address, 1315);
    pix(125, 1);
    chk("p125_on", bus.sprite_on, 0);
    chk("p125_hold", bus.memory_address, 1315);

    nc = 0;
    for (int x = 100; x <= 124; x++) begin
      pix(x, 1);
      chk("sweep_cf", bus.count_finished, (x == 119 || x == 124));
      if (bus.count_finished) nc++;
    end
    chk("sweep_cf_count", nc, 2);

    bus.line_y = 55; bus.line_start = 1;
    @(negedge clk);
    bus.line_start = 0;
    bus.wr_en = 1; bus.wr_sel = 2; bus.wr_data = mk(1, 1, 55, 300);
    k = 0;
    while (!bus.wr_ready && k < 20) begin
      k++;
      @(negedge clk);
    end
    chk("stall_cycles", k, 8);
    @(negedge clk);
    bus.wr_en = 0;
    pix(300, 1);
    chk("ready_write_deferred", bus.sprite_on, 0);
    start_line(55, 0);
    pix(300, 1);
    chk("p300_id", bus.sprite_id, 2);
    chk("p300_addr", bus.memory_address, 400);

    start_line(70, 0);
    pix(103, 1);
    chk("y70_103", bus.sprite_on, 0);
    pix(110, 1);
    chk("y70_110", bus.sprite_on, 0);
    pix(120, 1);
    chk("y70_120", bus.sprite_on, 0);

    wr(0, mk(0, 2, 50, 100));
    start_line(55, 0);
    pix(103, 1);
    chk("disabled_103", bus.sprite_on, 0);
    pix(110, 1);
    chk("s1_110_id", bus.sprite_id, 1);
    chk("s1_110_addr", bus.memory_address, 1305);

    bus.line_y = 55; bus.line_start = 1;
    @(negedge clk);
    bus.line_start = 0;
    repeat (2) @(negedge clk);
    start_line(55, 1);

    repeat (3) @(negedge clk);
    bus.pixel_tick = 1; bus.pixel_x = 110; bus.active_area = 1;
    bus.line_y = 70; bus.line_start = 1;
    @(negedge clk);
    bus.pixel_tick = 0; bus.line_start = 0;
    chk("simul_old_line", bus.sprite_on, 1);
    wait_ready();

    start_line(55, 0);
    pix(110, 1);
    chk("pre_reset_on", bus.sprite_on, 1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("rst2_on", bus.sprite_on, 0);
    chk("rst2_id", bus.sprite_id, 0);
    chk("rst2_addr", bus.memory_address, 0);
    chk("rst2_line_ready", bus.line_ready, 0);
    start_line(55, 0);
    pix(110, 1);
    chk("cleared_110", bus.sprite_on, 0);
    pix(300, 1);
    chk("cleared_300", bus.sprite_on, 0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sprite_line_engine.md
# sprite_line_engine

Multi-sprite successor to the single-sprite print/line-counter pair of the sprite console. The block holds a table of `NUM_SPRITES` sprite descriptors. During horizontal blanking it scans that table once per scanline to find which sprites intersect the line. During the active area it emits, one clock after each pixel tick, the sprite-memory address of the highest-priority sprite covering the current pixel. Everything runs on the 100 MHz system clock; pixel rate is conveyed by a `pixel_tick` enable rather than a second clock.

## Interface
Parameters:
- `NUM_SPRITES`, default 8: number of descriptor entries. Range 1..32.
- `size_x`, default 10: `pixel_x` width.
- `size_y`, default 9: `pixel_y` / `line_y` width.
- `size_address`, default 17: memory address width.
- `SPRITE_W`, default 20: sprite width in pixels.
- `SPRITE_H`, default 20: sprite height in lines.

Ports:
- `clk`, in, 1: system clock. Single clock domain.
- `reset`, in, 1: synchronous, active-high reset.
- `wr_en`, in, 1: descriptor write request.
- `wr_sel`, in, clog2(NUM_SPRITES): descriptor index.
- `wr_data`, in, 32: descriptor word.
  - [31] enable.
  - [30:22] slot.
  - [21:19] reserved.
  - [18:10] y.
  - [9:0] x.
- `wr_ready`, out, 1: write accepted this cycle when `wr_en` & `wr_ready`.
- `line_start`, in, 1: pulse requesting a scan for line `line_y`.
- `line_y`, in, size_y: scanline to prepare.
- `line_ready`, out, 1: the active-line mask for the latched `line_y` is valid.
- `pixel_tick`, in, 1: one-cycle pixel enable (1 in 4 clocks at 25 MHz pixel rate).
- `active_area`, in, 1: the current pixel is visible.
- `pixel_x`, in, size_x: current pixel column.
- `sprite_on`, out, 1: the registered pixel hits a sprite.
- `sprite_id`, out, clog2(NUM_SPRITES): index of the winning sprite.
- `memory_address`, out, size_address: sprite memory address.
- `count_finished`, out, 1: the pixel is the last column (`SPRITE_W-1`) of the winning sprite's line.

## Operation
- Descriptor table: `NUM_SPRITES` × 32-bit registers. Reset clears every entry to 0 (all disabled).
- FSM states: `IDLE`, `SCAN`, `READY`.
  - `IDLE`: `line_start` → latch `line_y`, set scan index to 0, clear mask, go to `SCAN`.
  - `SCAN`: one descriptor per clock.
    - `mask[i] = en_i & (line_y >= y_i) & (line_y < y_i + SPRITE_H)`.
    - The comparison is done at size_y+1 bits, so there is no wrap-around; a sprite near the bottom edge is simply clipped.
    - After index `NUM_SPRITES-1`, go to `READY`.
  - `READY`: `line_ready`=1. `line_start` → re-latch and go to `SCAN` (mask cleared).
  - `line_start` during `SCAN` restarts the scan at index 0 with the new `line_y`.
- `wr_ready = (state != SCAN)`. Writes are stalled during a scan.
- A write in `READY` updates the table but not the current mask. It takes effect at the next `line_start`.
- Pixel stage: on `pixel_tick` & `active_area` & `line_ready`:
  - `hit_i = mask[i] & (pixel_x >= x_i) & (pixel_x < x_i + SPRITE_W)`, compared at size_x+1 bits.
  - Winner = lowest index with `hit_i`=1.
  - `memory_address = slot*SPRITE_W*SPRITE_H + (line_y - y)*SPRITE_W + (pixel_x - x)`, truncated to size_address.
  - `count_finished = (pixel_x - x == SPRITE_W-1)`.
- If there is no hit, or the tick arrives without `active_area` or `line_ready`:
  - `sprite_on`=0, `count_finished`=0.
  - `sprite_id` and `memory_address` hold their previous values.
- Reset values: all outputs 0, `wr_ready`=1, state `IDLE`, mask 0.
- Reset mid-scan or mid-line aborts immediately. Nothing is emitted until a new `line_start` completes a scan.

## Timing
- Write: the table updates on the clock edge where `wr_en` & `wr_ready`.
- Scan: `line_start` sampled at edge N.
  - `SCAN` occupies edges N+1..N+NUM_SPRITES.
  - `line_ready`=1 from edge N+NUM_SPRITES+1.
  - `wr_ready`=0 for exactly NUM_SPRITES cycles.
- Pixel latency: outputs register at the edge where `pixel_tick` is sampled and are visible the following cycle. They are held until the next `pixel_tick`.
- `count_finished` and `sprite_on` persist for one full pixel period (ticks apart), not a single clock.
- Simultaneous `line_start` and `pixel_tick`: the pixel is evaluated with the old mask and `line_y`, then the scan starts.

## Test plan
- Reset, then write sprite 0 = {en=1, slot=2, y=50, x=100}, `line_start` with `line_y`=55 → `line_ready` rises 9 clocks later (NUM_SPRITES=8); `pixel_x`=103 tick → `sprite_on`=1, `sprite_id`=0, `memory_address`=903.
- Add sprite 1 = {en=1, slot=3, y=50, x=105}, same line:
  - `pixel_x`=110 → id 0, address 910.
  - `pixel_x`=120 → id 1, address 1315.
  - `pixel_x`=125 → `sprite_on`=0.
- Sweep `pixel_x` 100..124: `count_finished`=1 only at 119 (sprite 0) and 124 (sprite 1).
- `wr_en` during `SCAN` → `wr_ready`=0 and the entry is unchanged; the write is accepted the first cycle after the scan completes.
- `line_y`=70 (outside 50..69) or sprite with en=0 → no hit for any `pixel_x`; `line_start` mid-scan restarts and `line_ready` is delayed by a full NUM_SPRITES.
- Assert `reset` while `READY` and `sprite_on`=1 → next cycle all outputs 0, `line_ready`=0, table cleared.
